// File: rtl/pad_arbiter.sv
// Round-robin, packet-granular arbiter feeding the pad stage from NUM_QUEUES
// sources through private 4-word fall-through buffers. Optional macro: PAD_ARB_PKT_CNT_EN.
module pad_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH/8,
  parameter int NUM_QUEUES = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy
`ifdef PAD_ARB_PKT_CNT_EN
  ,
  output logic [NUM_QUEUES*16-1:0]         pkt_cnt
`endif
);

  localparam int GW = $clog2(NUM_QUEUES);
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_PKT  = 1'b1;

  logic [2:0]            fifo_cnt  [NUM_QUEUES];
  logic [DATA_WIDTH-1:0] head_data [NUM_QUEUES];
  logic [CTRL_WIDTH-1:0] head_ctrl [NUM_QUEUES];

  logic [0:0]            state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         idx;
  logic                  found;
  logic                  in_body;
  logic                  pop;
  logic                  eop;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CTRL_WIDTH-1:0] sel_ctrl;

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem_data [4];
    logic [CTRL_WIDTH-1:0] mem_ctrl [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            cnt;
    logic                  push;
    logic                  pop_q;

    // A write into a full buffer is dropped outright so held words stay intact.
    assign push  = in_wr[q] && (cnt != 3'd4);
    assign pop_q = pop && (grant == GW'(q));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 2'd1;
        if (pop_q) rd_ptr <= rd_ptr + 2'd1;
        if (push && !pop_q)      cnt <= cnt + 3'd1;
        else if (!push && pop_q) cnt <= cnt - 3'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem_data[wr_ptr] <= in_data[q*DATA_WIDTH +: DATA_WIDTH];
        mem_ctrl[wr_ptr] <= in_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH];
      end
    end

    assign fifo_cnt[q]  = cnt;
    assign head_data[q] = mem_data[rd_ptr];
    assign head_ctrl[q] = mem_ctrl[rd_ptr];
    assign in_rdy[q]    = (cnt < 3'd3);
  end

  assign sel_data = head_data[grant];
  assign sel_ctrl = head_ctrl[grant];
  assign pop      = (state == ARB_PKT) && out_rdy && (fifo_cnt[grant] != 3'd0);
  assign eop      = (sel_ctrl != '0) && in_body;

  // Scan starts one past the last winner, so the previous winner is checked last.
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    idx   = last_grant;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      idx = GW'((int'(last_grant) + i) % NUM_QUEUES);
      if (!found && (fifo_cnt[idx] != 3'd0)) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_QUEUES - 1);
      in_body    <= 1'b0;
      out_wr     <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= '0;
    end else begin
      out_wr <= pop;
      if (pop) begin
        out_data <= sel_data;
        out_ctrl <= sel_ctrl;
      end
      case (state)
        ARB_IDLE: begin
          if (found) begin
            grant      <= pick;
            last_grant <= pick;
            in_body    <= 1'b0;
            state      <= ARB_PKT;
          end
        end
        default: begin
          // An empty buffer mid-packet simply stalls here; sources never switch early.
          if (pop) begin
            if (eop) begin
              in_body <= 1'b0;
              state   <= ARB_IDLE;
            end else if (sel_ctrl == '0) begin
              in_body <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef PAD_ARB_PKT_CNT_EN
  logic [15:0] cnt_q [NUM_QUEUES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= '0;
    end else if (pop && eop) begin
      cnt_q[grant] <= cnt_q[grant] + 16'd1;
    end
  end

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_cnt
    assign pkt_cnt[q*16 +: 16] = cnt_q[q];
  end
`else
  // Packet counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pad_arbiter.sv
// Self-checking bench for pad_arbiter: per-source expected-packet queues checked
// against the forwarded stream, plus cycle-accurate latency, gap and backpressure checks.
module tb_pad_arbiter;
  localparam int NQ = 4;
  localparam int DW = 64;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NQ*DW-1:0] in_data = '0;
  logic [NQ*CW-1:0] in_ctrl = '0;
  logic [NQ-1:0]    in_wr = '0;
  logic [NQ-1:0]    in_rdy;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy = 1'b0;
`ifdef PAD_ARB_PKT_CNT_EN
  logic [NQ*16-1:0] pkt_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int wr_cyc0 = -1;

  logic [71:0] pend [NQ][$];
  logic [71:0] expq [NQ][$];
  logic [71:0] obs_w [$];
  int          obs_c [$];
  bit          rdy_at [int];
  int          pkt_src [$];
  int          pkt_start [$];
  int          pkt_end [$];
  int          npkts [NQ];

  pad_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .in_wr(in_wr),
    .in_rdy(in_rdy),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .out_wr(out_wr),
    .out_rdy(out_rdy)
`ifdef PAD_ARB_PKT_CNT_EN
    ,
    .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor samples just after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (reset_n && out_wr) begin
      obs_w.push_back({out_ctrl, out_data});
      obs_c.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ~out_rdy;
      2:       out_rdy = 1'($urandom % 2);
      default: out_rdy = 1'b0;
    endcase
    rdy_at[cyc] = out_rdy;
  end

  task automatic do_reset();
    reset_n = 1'b0;
    in_wr   = '0;
    in_data = '0;
    in_ctrl = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    obs_w.delete();
    obs_c.delete();
    pkt_src.delete();
    pkt_start.delete();
    pkt_end.delete();
    for (int q = 0; q < NQ; q++) begin
      pend[q].delete();
      expq[q].delete();
      npkts[q] = 0;
    end
    @(negedge clk);
  endtask

  // Builds one packet (headers, bodies, one-hot end) tagged with its source in data[63:56].
  task automatic add_pkt(input int q, input int nhdr, input int nbody,
                         input logic [7:0] hdr_ctrl, input logic [7:0] end_ctrl);
    logic [71:0] w;
    logic [7:0]  c;
    int          n;
    n = 0;
    for (int h = 0; h < nhdr; h++) begin
      c = (hdr_ctrl != 0) ? hdr_ctrl : 8'($urandom_range(1, 255));
      w = {c, 8'(q), 8'(npkts[q]), 16'(n), 32'($urandom)};
      pend[q].push_back(w); expq[q].push_back(w); n++;
    end
    for (int b = 0; b < nbody; b++) begin
      w = {8'h00, 8'(q), 8'(npkts[q]), 16'(n), 32'($urandom)};
      pend[q].push_back(w); expq[q].push_back(w); n++;
    end
    c = (end_ctrl != 0) ? end_ctrl : 8'(1 << $urandom_range(0, 7));
    w = {c, 8'(q), 8'(npkts[q]), 16'(n), 32'($urandom)};
    pend[q].push_back(w); expq[q].push_back(w);
    npkts[q]++;
  endtask

  // Called at a falling edge; returns at the next one with the word captured.
  task automatic write_word(input int q);
    logic [71:0] w;
    int n;
    n = 0;
    while (!in_rdy[q] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL in_rdy_wait q%0d: in_rdy stayed %b, required 1", q, in_rdy[q]);
    end
    w = pend[q].pop_front();
    in_data[q*DW +: DW] = w[63:0];
    in_ctrl[q*CW +: CW] = w[71:64];
    in_wr[q] = 1'b1;
    if (wr_cyc0 < 0) wr_cyc0 = cyc;
    @(negedge clk);
    in_wr[q] = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k;
    k = 0;
    while (obs_w.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (obs_w.size() < n) begin
      errors++;
      $display("[TB] FAIL wait_obs: got %0d words, required %0d", obs_w.size(), n);
    end
  endtask

  // All sources write whenever ready (with probability prob%) until every word is out.
  task automatic drive_traffic(input int prob, input int budget);
    logic [71:0] w;
    int total;
    int n;
    bit done;
    total = 0;
    for (int q = 0; q < NQ; q++) total += pend[q].size();
    n = 0;
    done = 0;
    wr_cyc0 = -1;
    while (!done && n < budget) begin
      @(negedge clk);
      in_wr = '0;
      for (int q = 0; q < NQ; q++) begin
        if (pend[q].size() > 0 && in_rdy[q] && int'($urandom % 100) < prob) begin
          w = pend[q].pop_front();
          in_data[q*DW +: DW] = w[63:0];
          in_ctrl[q*CW +: CW] = w[71:64];
          in_wr[q] = 1'b1;
          if (wr_cyc0 < 0) wr_cyc0 = cyc;
        end
      end
      done = (obs_w.size() >= total);
      for (int q = 0; q < NQ; q++) if (pend[q].size() > 0) done = 0;
      n++;
    end
    in_wr = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (obs_w.size() != total) begin
      errors++;
      $display("[TB] FAIL word_total: got %0d words, required %0d", obs_w.size(), total);
    end
  endtask

  // Walks the forwarded stream packet by packet against the per-source expectations.
  task automatic check_stream(input bit contig);
    logic [71:0] w;
    logic [71:0] e;
    int src;
    bit body;
    src = -1;
    body = 0;
    for (int i = 0; i < obs_w.size(); i++) begin
      w = obs_w[i];
      if (src < 0) begin
        src = int'(w[63:56]);
        body = 0;
        pkt_src.push_back(src);
        pkt_start.push_back(obs_c[i]);
      end else if (contig) begin
        checks++;
        if (obs_c[i] != obs_c[i-1] + 1) begin
          errors++;
          $display("[TB] FAIL contiguous word %0d: at cycle %0d, required %0d", i, obs_c[i], obs_c[i-1] + 1);
        end
      end
      checks++;
      if (!rdy_at.exists(obs_c[i] - 1) || rdy_at[obs_c[i] - 1] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rdy_rule word %0d: out_wr high at cycle %0d without out_rdy in prior cycle", i, obs_c[i]);
      end
      checks++;
      if (src >= NQ || expq[src].size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected word %0d: got %h, no word required", i, w);
        src = -1;
      end else begin
        e = expq[src].pop_front();
        if (w !== e) begin
          errors++;
          $display("[TB] FAIL word %0d src %0d: got %h, required %h", i, src, w, e);
        end
        if (e[71:64] != 0 && body) begin
          pkt_end.push_back(obs_c[i]);
          src = -1;
        end else if (e[71:64] == 0) begin
          body = 1;
        end
      end
    end
    for (int q = 0; q < NQ; q++) begin
      checks++;
      if (expq[q].size() != 0) begin
        errors++;
        $display("[TB] FAIL missing q%0d: %0d words never forwarded, required 0", q, expq[q].size());
      end
    end
  endtask

  task automatic test_reset();
    rdy_mode = 0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_wr: got %b, required 0", out_wr); end
    do_reset();
    checks++;
    if (out_wr !== 1'b0) begin errors++; $display("[TB] FAIL idle_out_wr: got %b, required 0", out_wr); end
    checks++;
    if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h, required 0", out_data); end
    checks++;
    if (out_ctrl !== '0) begin errors++; $display("[TB] FAIL reset_out_ctrl: got %h, required 0", out_ctrl); end
    checks++;
    if (in_rdy !== '1) begin errors++; $display("[TB] FAIL reset_in_rdy: got %b, required 1111", in_rdy); end
`ifdef PAD_ARB_PKT_CNT_EN
    checks++;
    if (pkt_cnt !== '0) begin errors++; $display("[TB] FAIL reset_pkt_cnt: got %h, required 0", pkt_cnt); end
`endif
  endtask

  task automatic test_single();
    rdy_mode = 0;
    do_reset();
    add_pkt(0, 1, 3, 8'hFF, 8'h10);
    drive_traffic(100, 200);
    check_stream(1);
    checks++;
    if (obs_c.size() == 0 || obs_c[0] - wr_cyc0 != 3) begin
      errors++;
      $display("[TB] FAIL single_latency: got %0d cycles, required 3", (obs_c.size() == 0) ? -1 : obs_c[0] - wr_cyc0);
    end
`ifdef PAD_ARB_PKT_CNT_EN
    checks++;
    if (pkt_cnt[15:0] !== 16'd1) begin errors++; $display("[TB] FAIL single_pkt_cnt: got %0d, required 1", pkt_cnt[15:0]); end
`endif
  endtask

  task automatic test_fairness();
    rdy_mode = 0;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < NQ; q++) add_pkt(q, 1, 2, 8'h00, 8'h00);
    drive_traffic(100, 500);
    check_stream(1);
    checks++;
    if (pkt_src.size() != 8) begin
      errors++;
      $display("[TB] FAIL fair_pkt_count: got %0d packets, required 8", pkt_src.size());
    end
    for (int i = 0; i < pkt_src.size() && i < 8; i++) begin
      checks++;
      if (pkt_src[i] != i % NQ) begin
        errors++;
        $display("[TB] FAIL fair_order pkt %0d: got q%0d, required q%0d", i, pkt_src[i], i % NQ);
      end
      if (i > 0 && i < pkt_end.size() + 1) begin
        checks++;
        if (pkt_start[i] != pkt_end[i-1] + 2) begin
          errors++;
          $display("[TB] FAIL fair_gap pkt %0d: starts cycle %0d, required %0d", i, pkt_start[i], pkt_end[i-1] + 2);
        end
      end
    end
  endtask

  task automatic test_starvation();
    rdy_mode = 0;
    do_reset();
    add_pkt(2, 1, 3, 8'h00, 8'h00);
    add_pkt(1, 0, 2, 8'h00, 8'h00);
    write_word(2);
    write_word(2);
    write_word(2);
    for (int k = 0; k < 3; k++) write_word(1);
    repeat (5) @(negedge clk);
    write_word(2);
    write_word(2);
    wait_obs(8, 100);
    repeat (5) @(negedge clk);
    check_stream(0);
    checks++;
    if (pkt_src.size() != 2 || pkt_src[0] != 2 || pkt_src[1] != 1) begin
      errors++;
      $display("[TB] FAIL starve_order: got %0d packets first q%0d, required q2 then q1", pkt_src.size(), (pkt_src.size() > 0) ? pkt_src[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    rdy_mode = 3;
    do_reset();
    add_pkt(0, 2, 3, 8'h00, 8'h00);
    write_word(0);
    write_word(0);
    checks++;
    if (in_rdy[0] !== 1'b1) begin errors++; $display("[TB] FAIL in_rdy_two: got %b, required 1", in_rdy[0]); end
    write_word(0);
    checks++;
    if (in_rdy[0] !== 1'b0) begin errors++; $display("[TB] FAIL in_rdy_three: got %b, required 0", in_rdy[0]); end
    rdy_mode = 1;
    write_word(0);
    write_word(0);
    write_word(0);
    wait_obs(6, 100);
    repeat (10) @(negedge clk);
    check_stream(0);
    checks++;
    if (obs_w.size() != 6) begin errors++; $display("[TB] FAIL bp_count: got %0d words, required 6", obs_w.size()); end
  endtask

  task automatic test_reset_mid();
    int k;
    rdy_mode = 3;
    do_reset();
    add_pkt(0, 1, 3, 8'h00, 8'h00);
    write_word(0);
    write_word(0);
    write_word(0);
    rdy_mode = 0;
    k = 0;
    while (obs_w.size() < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_w.size() != 2) begin errors++; $display("[TB] FAIL mid_words_before: got %0d, required 2", obs_w.size()); end
    checks++;
    if (out_wr !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_wr: got %b, required 0", out_wr); end
    checks++;
    if (out_data !== '0) begin errors++; $display("[TB] FAIL mid_out_data: got %h, required 0", out_data); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pend[0].delete();
    expq[0].delete();
    obs_w.delete();
    obs_c.delete();
    pkt_src.delete();
    pkt_start.delete();
    pkt_end.delete();
    @(negedge clk);
    checks++;
    if (in_rdy !== '1) begin errors++; $display("[TB] FAIL mid_in_rdy: got %b, required 1111", in_rdy); end
    add_pkt(3, 0, 2, 8'h00, 8'h00);
    write_word(3);
    write_word(3);
    write_word(3);
    wait_obs(3, 100);
    repeat (10) @(negedge clk);
    check_stream(1);
    checks++;
    if (obs_w.size() != 3) begin errors++; $display("[TB] FAIL mid_new_count: got %0d words, required 3", obs_w.size()); end
  endtask

  task automatic test_random();
    rdy_mode = 2;
    do_reset();
    for (int q = 0; q < NQ; q++) begin
      int np;
      np = $urandom_range(2, 4);
      for (int p = 0; p < np; p++) add_pkt(q, $urandom_range(0, 2), $urandom_range(1, 4), 8'h00, 8'h00);
    end
    drive_traffic(60, 4000);
    check_stream(0);
`ifdef PAD_ARB_PKT_CNT_EN
    for (int q = 0; q < NQ; q++) begin
      checks++;
      if (pkt_cnt[q*16 +: 16] !== 16'(npkts[q])) begin
        errors++;
        $display("[TB] FAIL rand_pkt_cnt q%0d: got %0d, required %0d", q, pkt_cnt[q*16 +: 16], npkts[q]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
